// File: rtl/grf_scoreboard.sv
// ---------------------------------------------------------------------------
// grf_scoreboard
// General register file for the pipelined core: two combinational read ports,
// one synchronous write port, register 0 hardwired to zero, plus a per-register
// pending-write scoreboard (decode issues a destination, writeback retires it).
//
// Optional build macro: GRF_TRACE_EN
//   defined   -> every writeback (including writes to register 0) is printed
//                as "@<pc>: $<reg> <= <data>" for instruction tracing.
//   undefined -> no trace output, wpc is unused, fully synthesizable.
// ---------------------------------------------------------------------------
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       wpc,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_a,
    output logic              iss_ok,
    output logic              sb_err
);

    localparam int               NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Register storage and pending-write counters; entry 0 of each is never
    // modified outside reset, which is what keeps register 0 at zero.
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt  [NUM_REGS];

    // Per-register decoded issue/retire strobes (bit 0 always low).
    logic [NUM_REGS-1:0] iss_hit;
    logic [NUM_REGS-1:0] ret_hit;

    logic wr_nonzero;
    logic iss_nonzero;
    logic iss_same_retire;
    logic iss_saturated;
    logic iss_err;
    logic ret_err;

    // Decode the issue and retire addresses into one-hot strobes, skipping reg 0
    always_comb begin
        iss_hit = '0;
        ret_hit = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            iss_hit[r] = iss_v && (iss_a == ADDR_W'(r));
            ret_hit[r] = we && (wa == ADDR_W'(r));
        end
    end

    // Issue acceptance and scoreboard misuse detection for the current cycle
    always_comb begin
        wr_nonzero      = (wa != '0);
        iss_nonzero     = (iss_a != '0);
        iss_same_retire = we && (wa == iss_a);
        iss_saturated   = (cnt[iss_a] == CNT_MAX);
        // A retire of the same register in the same cycle frees a slot, so a
        // saturated counter can still accept the issue without overflowing.
        iss_ok  = iss_v && (!iss_nonzero || !iss_saturated || iss_same_retire);
        iss_err = iss_v && iss_nonzero && iss_saturated && !iss_same_retire;
        ret_err = we && wr_nonzero && (cnt[wa] == '0) && !(iss_v && (iss_a == wa));
    end

    // Register array write; register 0 silently discards its writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (we && wr_nonzero) begin
            regs[wa] <= wd;
        end
    end

    // Pending-write counters: issue increments, retire decrements, both
    // together cancel; the counter saturates at zero and at its maximum
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (iss_hit[r] && !ret_hit[r] && (cnt[r] != CNT_MAX)) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (ret_hit[r] && !iss_hit[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Sticky scoreboard error flag, only cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (iss_err || ret_err) begin
            sb_err <= 1'b1;
        end
    end

    // Combinational read ports with optional same-cycle write bypass
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if ((BYPASS != 0) && we && (wa == ra1)) begin
            rd1 = wd;
        end
        if ((BYPASS != 0) && we && (wa == ra2)) begin
            rd2 = wd;
        end
        if (ra1 == '0) begin
            rd1 = '0;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end
    end

    // Hazard flags come from registered counter state only
    always_comb begin
        busy1 = (ra1 != '0) && (cnt[ra1] != '0);
        busy2 = (ra2 != '0) && (cnt[ra2] != '0);
    end

`ifdef GRF_TRACE_EN
    // Instruction trace of every writeback, including discarded reg-0 writes
    always @(posedge clk) begin
        if (!reset && we) begin
            $display("@%h: $%d <= %h", wpc, wa, wd);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_grf_scoreboard
// Directed bench for grf_scoreboard (default parameters, BYPASS=1).
// Stimulus pushes hand-computed expectations into a queue; a monitor on the
// falling edge pops one entry per cycle and compares it against the outputs.
// ---------------------------------------------------------------------------
module tb_grf_scoreboard;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        busy1;
        logic        busy2;
        logic        iss_ok;
        logic        sb_err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic        iss_v;
    logic [4:0]  iss_a;
    logic        iss_ok;
    logic        sb_err;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_errors = 0;

    grf_scoreboard dut (
        .clk    (clk),
        .reset  (reset),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .busy1  (busy1),
        .busy2  (busy2),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .wpc    (wpc),
        .iss_v  (iss_v),
        .iss_a  (iss_a),
        .iss_ok (iss_ok),
        .sb_err (sb_err)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs
    task automatic applyStimulus(input logic rst, input logic w_en, input logic [4:0] w_a,
                                 input logic [31:0] w_d, input logic [4:0] r_a1,
                                 input logic [4:0] r_a2, input logic i_v, input logic [4:0] i_a);
        reset = rst;
        we    = w_en;
        wa    = w_a;
        wd    = w_d;
        wpc   = 32'h0000_1000 + {27'd0, w_a};
        ra1   = r_a1;
        ra2   = r_a2;
        iss_v = i_v;
        iss_a = i_a;
    endtask

    // Queue the expected outputs for the cycle just driven
    task automatic checkOutput(input string nm, input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                               input logic e_b1, input logic e_b2, input logic e_ok,
                               input logic e_err);
        exp_t e;
        e.name   = nm;
        e.rd1    = e_rd1;
        e.rd2    = e_rd2;
        e.busy1  = e_b1;
        e.busy2  = e_b2;
        e.iss_ok = e_ok;
        e.sb_err = e_err;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic compareField(input string nm, input string field, input logic [31:0] act,
                                input logic [31:0] req);
        num_checks++;
        if (act !== req) begin
            num_errors++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", nm, field, act, req);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compareField(e.name, "rd1",    rd1,             e.rd1);
            compareField(e.name, "rd2",    rd2,             e.rd2);
            compareField(e.name, "busy1",  {31'd0, busy1},  {31'd0, e.busy1});
            compareField(e.name, "busy2",  {31'd0, busy2},  {31'd0, e.busy2});
            compareField(e.name, "iss_ok", {31'd0, iss_ok}, {31'd0, e.iss_ok});
            compareField(e.name, "sb_err", {31'd0, sb_err}, {31'd0, e.sb_err});
        end
    end

    // Directed stimulus sequence
    initial begin
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        nextCycle();
        nextCycle();

        // Every register reads zero after reset, no busy, no error
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
            checkOutput("reset_read", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            nextCycle();
        end

        // Register 0: issue accepted without counting, write discarded
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
        checkOutput("r0_issue", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("r0_write_same", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("r0_write_next", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Three issues to reg 7 fill its counter
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7);
            checkOutput("iss7_fill", 32'h0, 32'h0, k != 0, k != 0, 1'b1, 1'b0);
            nextCycle();
        end
        // Issue plus retire of reg 7 at saturation: accepted, no error
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 1'b1, 5'd7);
        checkOutput("iss7_sat_cancel", 32'h77, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        nextCycle();
        // Fourth outstanding issue is refused
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7);
        checkOutput("iss7_overflow", 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
        checkOutput("iss7_err_set", 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        // Three retires drain reg 7
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 5'd7, 32'h70 + k, 5'd7, 5'd0, 1'b0, 5'd0);
            checkOutput("ret7_drain", 32'h70 + k, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
        checkOutput("ret7_idle", 32'h72, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();

        // Put data in reg 3, then reset with a concurrent write and issue to it
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd7, 1'b0, 5'd0);
        checkOutput("wr3", 32'h3333_3333, 32'h72, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd0, 1'b1, 5'd3);
        checkOutput("reset_mid", 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0);
        checkOutput("reset_mid_after", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Same-cycle issue and retire of reg 9 cancel; then retire on zero errors
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        checkOutput("iss9", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b1, 5'd9);
        checkOutput("iss9_ret9", 32'h99, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("cnt9_still1", 32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h98, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("ret9", 32'h98, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("cnt9_zero", 32'h98, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h97, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("ret9_underflow", 32'h97, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("ret9_err_set", 32'h97, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();

        // Write bypass on both ports, including the top register
        applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd6, 1'b0, 5'd0);
        checkOutput("byp5", 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd6, 32'hA5A5_0F0F, 5'd5, 5'd6, 1'b0, 5'd0);
        checkOutput("byp6", 32'h1234_5678, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd5, 1'b0, 5'd0);
        checkOutput("byp31", 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd31, 1'b0, 5'd0);
        checkOutput("stored_6_31", 32'hA5A5_0F0F, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();

        // Final reset clears data and the sticky error
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd5, 1'b0, 5'd0);
        checkOutput("final_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Allow the monitor to drain, bounded
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
            nextCycle();
        end
        if (exp_q.size() > 0) begin
            num_checks++;
            num_errors++;
            $display("[TB] FAIL drain: %0d pending, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
